bkg_scroll_fetch: RTL and testbench
===================================

# bkg_scroll_fetch

Pixel-fetch stage between the VGA timing generator and the 160×160, 24-bit background RAM. It maps the current DrawX/DrawY to a RAM read address with 4× upscaling and a wrap-around vertical scroll offset, then returns the RAM's registered pixel as RGB. VGA syncs are delayed to stay aligned with that RGB. Scroll requests from game logic are applied only at the start of vertical sync, so a frame never tears.

## Interface
- IMG_W, 160, background width in texels
- IMG_H, 160, background height in texels (scroll modulus)
- Clk  in  1  system/pixel clock; all logic on posedge
- Reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- blank_n  in  1  high = visible pixel
- hs_in, vs_in  in  1  active-low syncs from timing generator
- scroll_req  in  1  one-cycle request strobe
- scroll_delta  in  8  rows to scroll, taken mod IMG_H
- scroll_ack  out  1  one-cycle pulse when the offset has been applied
- scroll_busy  out  1  high while a request is pending
- read_address  out  15  background RAM read address (registered)
- ram_data  in  24  RAM output, valid 1 cycle after read_address
- Red, Green, Blue  out  8 each  pixel colour
- hs_out, vs_out  out  1  syncs aligned to RGB

## Operation
- col = DrawX>>2 (0..159); vrow = DrawY>>2 (0..119).
- row = vrow + offset; if row ≥ IMG_H, subtract IMG_H once.
- read_address = row*160 + col, computed as (row<<7)+(row<<5)+col. Maximum is 25599, so 15 bits is enough.
- RGB = ram_data[23:16], [15:8], [7:0]. RGB is forced to 0 when the delayed blank_n is low.
- Scroll FSM states are IDLE, PENDING and APPLY.
  - **IDLE:** scroll_req loads pending = delta mod 160 (if delta ≥ 160, subtract 160) and moves to PENDING.
  - **PENDING:** scroll_busy = 1.
    - A further scroll_req accumulates: pending = (pending + d) mod 160, with one conditional subtract.
    - A vs_in falling edge (vs_d = 1, vs_in = 0) moves the FSM to APPLY.
  - **APPLY:** offset = (offset + pending) mod 160 and scroll_ack = 1 for this one cycle; then go to IDLE.
    - A scroll_req in the APPLY cycle starts a fresh pending and goes to PENDING instead.
- offset changes only in APPLY.
- Reset mid-operation clears offset, pending and FSM state; the pending request is dropped and no ack is issued.

## Timing
- Reset values:
  - read_address 0
  - Red/Green/Blue 0
  - hs_out, vs_out 1 (syncs idle high)
  - scroll_ack 0, scroll_busy 0
  - offset 0, FSM in IDLE
- Inputs sampled in cycle N: read_address valid in N+1, ram_data in N+2, RGB in N+3. Total latency is 3.
- hs/vs/blank_n pass through a 3-stage delay, so hs_out/vs_out match the RGB cycle.
- Scroll timing:
  - vs edge seen in cycle N gives APPLY (ack high) in N+1.
  - The new offset is used by addresses computed from N+2 onward.
- A request arriving the same cycle as the vs edge is merged into pending before APPLY.

## Configuration
- BKG_SCROLL_EN, when defined: scroll FSM, pending accumulator and offset register are present.
- When undefined:
  - offset is constant 0 and row = vrow.
  - scroll_ack and scroll_busy are tied 0; scroll_req and scroll_delta are ignored.
  - Fetch latency is unchanged.

## Structure
- bkg_pkg holds:
  - IMG_W, IMG_H, BKG_DEPTH = 25600, ADDR_W = 15, RGB_W = 24
  - PIPE_LAT = 3
  - scroll_state_t enum {IDLE, PENDING, APPLY}
  - mod-160 add helper function
- Sub-module bkg_scroll_ctrl contains the vs edge detect, FSM, pending accumulator, offset register and ack/busy. It is compiled in only under BKG_SCROLL_EN.

## Test plan
- **Reset:** assert Reset_n = 0 mid-frame → all outputs at the reset values above; offset = 0.
- **Basic fetch:** DrawX=5, DrawY=9, offset 0 → read_address 321 at N+1. With ram_data=0xAABBCC at N+2, RGB = AA/BB/CC at N+3; hs_out matches hs_in delayed 3 cycles.
- **Scroll by 40 mid-frame:** scroll_req with delta=40 → busy=1 and addresses unchanged until vs_in falls. Then ack pulses 1 cycle; DrawX=0, DrawY=0 then gives read_address 6400.
- **Wrap-around:** offset 150, DrawX=639, DrawY=476 → row 109, read_address 17599.
- **Accumulation:** deltas 100 then 200 before vs → pending 140, exactly one ack, offset 140.
- **Blank and reset during PENDING:** blank_n=0 with ram_data=0xFFFFFF → RGB 0. Reset_n low while PENDING → busy 0, no ack, offset 0.

Source files
------------

// File: rtl/bkg_pkg.sv
// Shared definitions for the background fetch path: image geometry, fetch
// pipeline depth, scroll FSM states and a wrap-around row adder.
package bkg_pkg;

    localparam int IMG_W     = 160;
    localparam int IMG_H     = 160;
    localparam int BKG_DEPTH = IMG_W * IMG_H;
    localparam int ADDR_W    = 15;
    localparam int RGB_W     = 24;
    localparam int PIPE_LAT  = 3;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLY
    } scroll_state_t;

    // Operands are each below IMG_H, or at most 255 for a raw delta, so one
    // conditional subtract always lands back in 0..IMG_H-1.
    function automatic logic [7:0] mod_h_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 9'(IMG_H)) begin
            sum = sum - 9'(IMG_H);
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/bkg_scroll_ctrl.sv
// Vertical scroll controller: queues scroll requests and commits them to the
// offset only at the start of vertical sync. Present only with BKG_SCROLL_EN.
`ifdef BKG_SCROLL_EN
module bkg_scroll_ctrl
    import bkg_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs_in,
    input  logic       scroll_req,
    input  logic [7:0] scroll_delta,
    output logic [7:0] offset,
    output logic       scroll_ack,
    output logic       scroll_busy
);

    scroll_state_t state, state_next;
    logic [7:0]    pending, pending_next, offset_next;
    logic [7:0]    delta_mod;
    logic          vs_d, vs_fall;

    assign delta_mod = mod_h_add(scroll_delta, 8'd0);
    assign vs_fall   = vs_d & ~vs_in;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            pending <= '0;
            offset  <= '0;
            vs_d    <= 1'b1;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            offset  <= offset_next;
            vs_d    <= vs_in;
        end
    end

    // A request in the same cycle as the vsync edge is folded into pending
    // before APPLY, and one arriving during APPLY opens a fresh pending.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        offset_next  = offset;
        scroll_ack   = 1'b0;
        scroll_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (scroll_req) begin
                    pending_next = delta_mod;
                    state_next   = PENDING;
                end
            end
            PENDING: begin
                scroll_busy = 1'b1;
                if (scroll_req) begin
                    pending_next = mod_h_add(pending, delta_mod);
                end
                if (vs_fall) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                scroll_ack  = 1'b1;
                offset_next = mod_h_add(offset, pending);
                state_next  = IDLE;
                if (scroll_req) begin
                    pending_next = delta_mod;
                    state_next   = PENDING;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
`endif

// File: rtl/bkg_scroll_fetch.sv
// Background pixel fetch: DrawX/DrawY -> 4x upscaled RAM address with vertical
// scroll, registered RAM data -> RGB, syncs delayed to match. BKG_SCROLL_EN adds scrolling.
module bkg_scroll_fetch
    import bkg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank_n,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              scroll_req,
    input  logic [7:0]        scroll_delta,
    output logic              scroll_ack,
    output logic              scroll_busy,
    output logic [ADDR_W-1:0] read_address,
    input  logic [RGB_W-1:0]  ram_data,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              hs_out,
    output logic              vs_out
);

    logic [7:0]          col, vrow, row;
    logic [ADDR_W-1:0]   addr_next;
    logic [PIPE_LAT-1:0] hs_pipe, vs_pipe, blank_pipe;
    logic                unused_low_bits;

    assign col             = DrawX[9:2];
    assign vrow            = DrawY[9:2];
    assign unused_low_bits = ^{DrawX[1:0], DrawY[1:0]};

`ifdef BKG_SCROLL_EN
    logic [7:0] offset;

    bkg_scroll_ctrl u_scroll_ctrl (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .vs_in        (vs_in),
        .scroll_req   (scroll_req),
        .scroll_delta (scroll_delta),
        .offset       (offset),
        .scroll_ack   (scroll_ack),
        .scroll_busy  (scroll_busy)
    );

    assign row = mod_h_add(vrow, offset);
`else
    logic unused_scroll;

    assign row           = vrow;
    assign scroll_ack    = 1'b0;
    assign scroll_busy   = 1'b0;
    assign unused_scroll = ^{scroll_req, scroll_delta};
`endif

    // row*160 as two shifts keeps the multiplier out of the pixel path.
    assign addr_next = (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(col);

    // blank_n is taken one stage early because the RGB register itself is the last stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            hs_pipe      <= '1;
            vs_pipe      <= '1;
            blank_pipe   <= '0;
            Red          <= '0;
            Green        <= '0;
            Blue         <= '0;
        end else begin
            read_address <= addr_next;
            hs_pipe      <= {hs_pipe[PIPE_LAT-2:0], hs_in};
            vs_pipe      <= {vs_pipe[PIPE_LAT-2:0], vs_in};
            blank_pipe   <= {blank_pipe[PIPE_LAT-2:0], blank_n};
            if (blank_pipe[PIPE_LAT-2]) begin
                Red   <= ram_data[23:16];
                Green <= ram_data[15:8];
                Blue  <= ram_data[7:0];
            end else begin
                Red   <= '0;
                Green <= '0;
                Blue  <= '0;
            end
        end
    end

    assign hs_out = hs_pipe[PIPE_LAT-1];
    assign vs_out = vs_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_bkg_scroll_fetch.sv
// Self-checking bench for bkg_scroll_fetch: a registered-RAM model feeds the DUT and a
// scoreboard checks address and RGB/sync latency; scroll tests run when BKG_SCROLL_EN is defined.
module tb_bkg_scroll_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank_n, hs_in, vs_in, scroll_req;
    logic [7:0]  scroll_delta;
    logic        scroll_ack, scroll_busy;
    logic [14:0] read_address;
    logic [23:0] ram_data;
    logic [7:0]  Red, Green, Blue;
    logic        hs_out, vs_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_off = 0;
    int model_pend = 0;

    logic        ram_force = 1'b0, force_q = 1'b0;
    logic [23:0] force_val = '0, force_val_q = '0;

    typedef struct {
        int          sample;
        int          addr;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t addr_q[$];
    exp_t pix_q[$];
    exp_t mon_e;

    bkg_scroll_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank_n      (blank_n),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .scroll_req   (scroll_req),
        .scroll_delta (scroll_delta),
        .scroll_ack   (scroll_ack),
        .scroll_busy  (scroll_busy),
        .read_address (read_address),
        .ram_data     (ram_data),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .hs_out       (hs_out),
        .vs_out       (vs_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [23:0] ram_pattern(input logic [14:0] a);
        return {a[7:0] ^ 8'hA5, 1'b1, a[14:8], ~a[7:0]};
    endfunction

    // Registered background RAM; a forced word replaces the lookup for one pixel.
    always @(posedge Clk) begin
        force_q     <= ram_force;
        force_val_q <= force_val;
        ram_data    <= force_q ? force_val_q : ram_pattern(read_address);
    end

    // Scoreboard: address one cycle after sampling, RGB and syncs three cycles after.
    always begin
        @(posedge Clk);
        #1;
        if (!Reset_n) begin
            addr_q.delete();
            pix_q.delete();
        end else begin
            if (addr_q.size() > 0 && addr_q[0].sample == cyc) begin
                mon_e = addr_q.pop_front();
                checks++;
                if (read_address !== 15'(mon_e.addr)) begin
                    errors++;
                    $display("[TB] FAIL sb_addr cyc=%0d: got %0d expected %0d", cyc, read_address, mon_e.addr);
                end
            end
            if (pix_q.size() > 0 && pix_q[0].sample + 2 == cyc) begin
                mon_e = pix_q.pop_front();
                checks++;
                if ({Red, Green, Blue} !== mon_e.rgb || hs_out !== mon_e.hs || vs_out !== mon_e.vs) begin
                    errors++;
                    $display("[TB] FAIL sb_pixel cyc=%0d: got rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b",
                             cyc, {Red, Green, Blue}, hs_out, vs_out, mon_e.rgb, mon_e.hs, mon_e.vs);
                end
            end
        end
    end

    task automatic drive_cycle(input int x, input int y, input logic blank, input logic hs,
                               input logic vs, input logic req, input int delta,
                               input logic fen, input logic [23:0] fval);
        exp_t e;
        int   a;
        @(negedge Clk);
        DrawX        = 10'(x);
        DrawY        = 10'(y);
        blank_n      = blank;
        hs_in        = hs;
        vs_in        = vs;
        scroll_req   = req;
        scroll_delta = 8'(delta);
        ram_force    = fen;
        force_val    = fval;
        if (Reset_n) begin
            a        = ((y / 4 + model_off) % 160) * 160 + x / 4;
            e.sample = cyc + 1;
            e.addr   = a;
            e.hs     = hs;
            e.vs     = vs;
            e.rgb    = !blank ? 24'h0 : (fen ? fval : ram_pattern(15'(a)));
            addr_q.push_back(e);
            pix_q.push_back(e);
        end
    endtask

    task automatic pix(input int x, input int y);
        drive_cycle(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 24'h0);
    endtask

    task automatic test_reset();
        repeat (4) drive_cycle(200, 300, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 24'h0);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        if (read_address !== 15'd0) begin errors++; $display("[TB] FAIL rst_addr: got %0d expected 0", read_address); end
        checks++;
        if ({Red, Green, Blue} !== 24'h0) begin errors++; $display("[TB] FAIL rst_rgb: got %h expected 000000", {Red, Green, Blue}); end
        checks++;
        if (hs_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_hs: got %b expected 1", hs_out); end
        checks++;
        if (vs_out !== 1'b1) begin errors++; $display("[TB] FAIL rst_vs: got %b expected 1", vs_out); end
        checks++;
        if (scroll_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack: got %b expected 0", scroll_ack); end
        checks++;
        if (scroll_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", scroll_busy); end
        @(negedge Clk);
        Reset_n = 1'b1;
        model_off  = 0;
        model_pend = 0;
    endtask

    task automatic test_basic_fetch();
        drive_cycle(5, 9, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 24'hAABBCC);
        @(posedge Clk);
        #2;
        checks++;
        if (read_address !== 15'd321) begin errors++; $display("[TB] FAIL basic_addr: got %0d expected 321", read_address); end
        pix(0, 0);
        pix(639, 479);
        @(posedge Clk);
        #2;
        checks++;
        if ({Red, Green, Blue} !== 24'hAABBCC) begin errors++; $display("[TB] FAIL basic_rgb: got %h expected aabbcc", {Red, Green, Blue}); end
        checks++;
        if (hs_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_hs: got %b expected 0", hs_out); end
        drive_cycle(100, 200, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 24'h0);
        drive_cycle(333, 47, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 24'h0);
        pix(4, 4);
        pix(638, 3);
    endtask

    task automatic test_blank();
        drive_cycle(8, 8, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 24'hFFFFFF);
        pix(12, 12);
        pix(16, 16);
        @(posedge Clk);
        #2;
        checks++;
        if ({Red, Green, Blue} !== 24'h0) begin errors++; $display("[TB] FAIL blank_rgb: got %h expected 000000", {Red, Green, Blue}); end
        pix(20, 20);
        pix(24, 24);
    endtask

`ifdef BKG_SCROLL_EN
    task automatic do_vsync(input int x, input int y, input logic req, input int delta,
                            output logic ack_n1, output logic ack_n2, output logic busy_n2);
        drive_cycle(x, y, 1'b1, 1'b1, 1'b0, req, delta, 1'b0, 24'h0);
        if (req) model_pend = (model_pend + delta % 160) % 160;
        drive_cycle(x, y, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 24'h0);
        ack_n1 = scroll_ack;
        model_off  = (model_off + model_pend) % 160;
        model_pend = 0;
        drive_cycle(x, y, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 24'h0);
        ack_n2  = scroll_ack;
        busy_n2 = scroll_busy;
    endtask

    task automatic test_scroll_40();
        logic a1, a2, b2;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 40, 1'b0, 24'h0);
        model_pend = 40;
        pix(0, 0);
        checks++;
        if (scroll_busy !== 1'b1) begin errors++; $display("[TB] FAIL s40_busy: got %b expected 1", scroll_busy); end
        repeat (4) pix(0, 0);
        checks++;
        if (scroll_ack !== 1'b0) begin errors++; $display("[TB] FAIL s40_early_ack: got %b expected 0", scroll_ack); end
        do_vsync(0, 0, 1'b0, 0, a1, a2, b2);
        checks++;
        if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("[TB] FAIL s40_ack: got %b%b expected 10", a1, a2); end
        checks++;
        if (b2 !== 1'b0) begin errors++; $display("[TB] FAIL s40_busy_after: got %b expected 0", b2); end
        @(posedge Clk);
        #2;
        checks++;
        if (read_address !== 15'd6400) begin errors++; $display("[TB] FAIL s40_addr: got %0d expected 6400", read_address); end
        pix(0, 0);
        pix(0, 0);
    endtask

    task automatic test_wrap();
        logic a1, a2, b2;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 110, 1'b0, 24'h0);
        model_pend = 110;
        pix(0, 0);
        do_vsync(0, 0, 1'b0, 0, a1, a2, b2);
        checks++;
        if (a1 !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ack: got %b expected 1", a1); end
        pix(639, 476);
        @(posedge Clk);
        #2;
        checks++;
        if (read_address !== 15'd17599) begin errors++; $display("[TB] FAIL wrap_addr: got %0d expected 17599", read_address); end
        pix(0, 36);
        pix(0, 40);
        pix(320, 239);
        pix(0, 0);
    endtask

    task automatic test_accumulate();
        logic a1, a2, b2;
        int   acks;
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        model_off  = 0;
        model_pend = 0;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 100, 1'b0, 24'h0);
        model_pend = 100;
        pix(4, 4);
        pix(4, 4);
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 200, 1'b0, 24'h0);
        model_pend = (model_pend + 200 % 160) % 160;
        pix(8, 8);
        checks++;
        if (scroll_busy !== 1'b1) begin errors++; $display("[TB] FAIL acc_busy: got %b expected 1", scroll_busy); end
        do_vsync(0, 0, 1'b0, 0, a1, a2, b2);
        acks = int'(a1) + int'(a2);
        repeat (4) begin
            pix(0, 0);
            acks += int'(scroll_ack);
        end
        checks++;
        if (acks != 1) begin errors++; $display("[TB] FAIL acc_ack_count: got %0d expected 1", acks); end
        @(posedge Clk);
        #2;
        checks++;
        if (read_address !== 15'd22400) begin errors++; $display("[TB] FAIL acc_addr: got %0d expected 22400", read_address); end
        pix(0, 0);
    endtask

    task automatic test_back_to_back();
        logic a1, a2, b2;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b0, 24'h0);
        model_pend = 5;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 7, 1'b0, 24'h0);
        model_pend = 12;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 20, 1'b0, 24'h0);
        checks++;
        if (scroll_ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack: got %b expected 1", scroll_ack); end
        model_off  = (model_off + model_pend) % 160;
        model_pend = 20;
        pix(0, 0);
        checks++;
        if (scroll_busy !== 1'b1 || scroll_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_repend: got busy=%b ack=%b expected busy=1 ack=0", scroll_busy, scroll_ack);
        end
        pix(0, 0);
        do_vsync(0, 0, 1'b0, 0, a1, a2, b2);
        checks++;
        if (a1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack2: got %b expected 1", a1); end
        pix(0, 0);
        @(posedge Clk);
        #2;
        checks++;
        if (read_address !== 15'd1920) begin errors++; $display("[TB] FAIL b2b_addr: got %0d expected 1920", read_address); end
        pix(0, 0);
    endtask

    task automatic test_pending_reset();
        int acks;
        drive_cycle(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 30, 1'b0, 24'h0);
        pix(0, 0);
        checks++;
        if (scroll_busy !== 1'b1) begin errors++; $display("[TB] FAIL prst_busy_pre: got %b expected 1", scroll_busy); end
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        if (scroll_busy !== 1'b0 || scroll_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prst_busy: got busy=%b ack=%b expected 0 0", scroll_busy, scroll_ack);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        model_off  = 0;
        model_pend = 0;
        pix(0, 4);
        acks = 0;
        drive_cycle(0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 24'h0);
        repeat (3) begin
            drive_cycle(0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 24'h0);
            acks += int'(scroll_ack);
        end
        checks++;
        if (acks != 0) begin errors++; $display("[TB] FAIL prst_ack: got %0d acks expected 0", acks); end
        pix(0, 4);
        @(posedge Clk);
        #2;
        checks++;
        if (read_address !== 15'd160) begin errors++; $display("[TB] FAIL prst_addr: got %0d expected 160", read_address); end
        pix(0, 0);
    endtask
`else
    task automatic test_scroll_ignored();
        int acks;
        int busy_seen;
        acks      = 0;
        busy_seen = 0;
        drive_cycle(0, 8, 1'b1, 1'b1, 1'b1, 1'b1, 40, 1'b0, 24'h0);
        repeat (2) begin
            pix(0, 8);
            busy_seen += int'(scroll_busy);
        end
        repeat (3) begin
            drive_cycle(0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 24'h0);
            acks += int'(scroll_ack);
            busy_seen += int'(scroll_busy);
        end
        checks++;
        if (acks != 0) begin errors++; $display("[TB] FAIL noscroll_ack: got %0d expected 0", acks); end
        checks++;
        if (busy_seen != 0) begin errors++; $display("[TB] FAIL noscroll_busy: got %0d expected 0", busy_seen); end
        pix(0, 8);
        @(posedge Clk);
        #2;
        checks++;
        if (read_address !== 15'd320) begin errors++; $display("[TB] FAIL noscroll_addr: got %0d expected 320", read_address); end
        pix(639, 476);
        pix(0, 0);
    endtask
`endif

    initial begin
        Reset_n      = 1'b0;
        DrawX        = '0;
        DrawY        = '0;
        blank_n      = 1'b1;
        hs_in        = 1'b1;
        vs_in        = 1'b1;
        scroll_req   = 1'b0;
        scroll_delta = '0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        test_reset();
        test_basic_fetch();
        test_blank();
`ifdef BKG_SCROLL_EN
        test_scroll_40();
        test_wrap();
        test_accumulate();
        test_back_to_back();
        test_pending_reset();
`else
        test_scroll_ignored();
`endif
        repeat (4) pix(0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
